// File: rtl/num_sep_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | num_sep_session_ctrl                                                        |
// | Sequences one matrix-entry session through the number separator and        |
// | streams validated matrix elements downstream with row/column tags.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module num_sep_session_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int MAX_DIM        = 5,
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  sep_clear,
  output logic                  payload_gate,
  input  logic                  sep_done,
  input  logic                  sep_invalid,
  input  logic [10:0]           sep_num_count,
  output logic [ADDR_WIDTH-1:0] sep_rd_addr,
  input  logic [DATA_WIDTH-1:0] sep_rd_data,
  output logic [DATA_WIDTH-1:0] elem_data,
  output logic [2:0]            elem_row,
  output logic [2:0]            elem_col,
  output logic                  elem_valid,
  input  logic                  elem_ready,
  output logic                  elem_last,
  output logic [2:0]            dim_rows,
  output logic [2:0]            dim_cols,
  output logic                  busy,
  output logic                  ok,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CLR_W-1:0] c_CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [TO_W-1:0]  c_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic signed [DATA_WIDTH-1:0] c_DIM_MIN = DATA_WIDTH'(1);
  localparam logic signed [DATA_WIDTH-1:0] c_DIM_MAX = DATA_WIDTH'(MAX_DIM);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0, S_CLEAR = 4'd1, S_WAIT  = 4'd2, S_HDR0  = 4'd3, S_HDR1 = 4'd4,
    S_HDR2  = 4'd5, S_CHECK = 4'd6, S_FETCH = 4'd7, S_LOAD  = 4'd8, S_SEND = 4'd9
  } state_t;

  state_t                  r_state, w_next;
  logic [CLR_W-1:0]        r_clr_cnt;
  logic [TO_W-1:0]         r_to_cnt;
  logic [DATA_WIDTH-1:0]   r_rows_raw, r_cols_raw, r_elem_data;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic [5:0]              r_idx;
  logic [2:0]              r_row, r_col, r_elem_row, r_elem_col, r_dim_rows, r_dim_cols;
  logic                    r_elem_last, r_ok, r_err;
  logic [1:0]              r_err_code, w_err_code;
  logic                    w_ok_set, w_err_set, w_hdr_ok;
  logic [10:0]             w_expect_count;
  logic [5:0]              w_total;

  // Count check is only meaningful once both dimensions are known to be in 1..MAX_DIM.
  assign w_expect_count = 11'd2 + 11'(r_rows_raw[2:0]) * 11'(r_cols_raw[2:0]);
  assign w_hdr_ok = ($signed(r_rows_raw) >= c_DIM_MIN) && ($signed(r_rows_raw) <= c_DIM_MAX) &&
                    ($signed(r_cols_raw) >= c_DIM_MIN) && ($signed(r_cols_raw) <= c_DIM_MAX) &&
                    (sep_num_count == w_expect_count);
  assign w_total = 6'(r_dim_rows) * 6'(r_dim_cols);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ok_set   = 1'b0;
    w_err_set  = 1'b0;
    w_err_code = r_err_code;
    case (r_state)
      S_IDLE: if (start && !abort) begin
        w_next     = S_CLEAR;
        w_err_code = 2'd0;
      end
      S_CLEAR: if (r_clr_cnt == c_CLR_LAST) w_next = S_WAIT;
      S_WAIT: begin
        if (sep_invalid) begin
          w_next = S_IDLE; w_err_set = 1'b1; w_err_code = 2'd1;
        end else if (sep_done) begin
          w_next = S_HDR0;
        end else if (r_to_cnt == c_TO_LAST) begin
          w_next = S_IDLE; w_err_set = 1'b1; w_err_code = 2'd3;
        end
      end
      S_HDR0:  w_next = S_HDR1;
      S_HDR1:  w_next = S_HDR2;
      S_HDR2:  w_next = S_CHECK;
      S_CHECK: begin
        if (w_hdr_ok) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_IDLE; w_err_set = 1'b1; w_err_code = 2'd2;
        end
      end
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = S_SEND;
      S_SEND: if (elem_ready) begin
        if (r_elem_last) begin
          w_next = S_IDLE; w_ok_set = 1'b1;
        end else begin
          w_next = S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Abort wins over everything and leaves no trace in ok/err/err_code.
    if (r_state != S_IDLE && abort) begin
      w_next     = S_IDLE;
      w_ok_set   = 1'b0;
      w_err_set  = 1'b0;
      w_err_code = r_err_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt   <= '0;
      r_to_cnt    <= '0;
      r_rows_raw  <= '0;
      r_cols_raw  <= '0;
      r_rd_addr   <= '0;
      r_idx       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_elem_data <= '0;
      r_elem_row  <= '0;
      r_elem_col  <= '0;
      r_elem_last <= 1'b0;
      r_dim_rows  <= '0;
      r_dim_cols  <= '0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_ok       <= w_ok_set;
      r_err      <= w_err_set;
      r_err_code <= w_err_code;
      r_clr_cnt  <= (r_state == S_CLEAR) ? r_clr_cnt + 1'b1 : '0;
      r_to_cnt   <= (r_state == S_WAIT) ? r_to_cnt + 1'b1 : '0;
      case (r_state)
        S_WAIT:  r_rd_addr <= '0;
        S_HDR0:  r_rd_addr <= ADDR_WIDTH'(1);
        S_HDR1:  r_rows_raw <= sep_rd_data;
        S_HDR2:  r_cols_raw <= sep_rd_data;
        S_CHECK: if (w_next == S_FETCH) begin
          r_dim_rows <= r_rows_raw[2:0];
          r_dim_cols <= r_cols_raw[2:0];
          r_idx      <= '0;
          r_row      <= '0;
          r_col      <= '0;
          r_rd_addr  <= ADDR_WIDTH'(2);
        end
        S_LOAD: begin
          r_elem_data <= sep_rd_data;
          r_elem_row  <= r_row;
          r_elem_col  <= r_col;
          r_elem_last <= (r_idx == w_total - 6'd1);
        end
        S_SEND: if (w_next == S_FETCH) begin
          r_idx     <= r_idx + 6'd1;
          r_rd_addr <= ADDR_WIDTH'(r_idx) + ADDR_WIDTH'(3);
          if (r_col == r_dim_cols - 3'd1) begin
            r_col <= '0;
            r_row <= r_row + 3'd1;
          end else begin
            r_col <= r_col + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sep_clear    = (r_state == S_CLEAR);
  assign payload_gate = (r_state == S_WAIT);
  assign elem_valid   = (r_state == S_SEND);
  assign busy         = (r_state != S_IDLE);
  assign sep_rd_addr  = r_rd_addr;
  assign elem_data    = r_elem_data;
  assign elem_row     = r_elem_row;
  assign elem_col     = r_elem_col;
  assign elem_last    = r_elem_last;
  assign dim_rows     = r_dim_rows;
  assign dim_cols     = r_dim_cols;
  assign ok           = r_ok;
  assign err          = r_err;
  assign err_code     = r_err_code;

endmodule
`default_nettype wire
